// File: rtl/dpram_be_pipe.sv
// dpram_be_pipe: true dual-port RAM with per-byte write enables, a pipelined
// read path (1 or 2 cycles) and a self-clearing init sweep.
//
// After reset, or after a clear_req pulse while running, the memory is swept
// to zero one word per cycle. Port requests are ignored until ready rises.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   clear_req                 pulse while ready=1 to re-zero the memory
//   ready                     1 = sweep done, port requests accepted
//   collision                 1 for one cycle after a same-address conflict
//   write_data_x, addr_x      write word and word address (x = a, b)
//   write_en_x, byte_en_x     write request and byte-lane enables
//   read_en_x                 read request
//   read_data_x, read_valid_x read word and its qualifier
module dpram_be_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  output logic                    ready,
  output logic                    collision,
  input  logic [DATA_WIDTH-1:0]   write_data_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic                    write_en_a,
  input  logic [DATA_WIDTH/8-1:0] byte_en_a,
  input  logic                    read_en_a,
  output logic [DATA_WIDTH-1:0]   read_data_a,
  output logic                    read_valid_a,
  input  logic [DATA_WIDTH-1:0]   write_data_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic                    write_en_b,
  input  logic [DATA_WIDTH/8-1:0] byte_en_b,
  input  logic                    read_en_b,
  output logic [DATA_WIDTH-1:0]   read_data_b,
  output logic                    read_valid_b
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
  logic                    collision_reg;
  logic                    sweep_we;
  logic                    wr_a, wr_b;
  logic [1:0]              rd_acc;
  logic [ADDR_WIDTH-1:0]   addr_p      [2];
  logic [DATA_WIDTH-1:0]   read_data_p [2];
  logic [1:0]              read_valid_p;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_INIT;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == ADDR_MAX) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_next   = ST_INIT;
          clr_cnt_next = '0;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready    = (state_reg == ST_RUN);
    sweep_we = (state_reg == ST_INIT);
  end

  assign wr_a      = ready & write_en_a;
  assign wr_b      = ready & write_en_b;
  assign rd_acc[0] = ready & read_en_a;
  assign rd_acc[1] = ready & read_en_b;
  assign addr_p[0] = addr_a;
  assign addr_p[1] = addr_b;

  // Memory write. Port A lanes are assigned after port B lanes so that a
  // lane enabled on both ports at the same address ends up with A's byte.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[clr_cnt_reg] <= '0;
    end else begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_b && byte_en_b[i]) mem[addr_b][8*i +: 8] <= write_data_b[8*i +: 8];
        if (wr_a && byte_en_a[i]) mem[addr_a][8*i +: 8] <= write_data_a[8*i +: 8];
      end
    end
  end

  // Same-address conflict flag, registered so it appears the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision_reg <= 1'b0;
    else     collision_reg <= ready && (addr_a == addr_b) &&
                              (write_en_a || read_en_a) && (write_en_b || read_en_b) &&
                              (write_en_a || write_en_b);
  end
  assign collision = collision_reg;

  // Read path per port. The array read always returns the pre-write word; in
  // new-data mode the lanes written this cycle are captured as a bypass and
  // merged after the read register, keeping the array read synchronous.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_WIDTH-1:0] byp_data;
      logic [BE_WIDTH-1:0]   byp_mask;
      logic [DATA_WIDTH-1:0] s1_old_reg, s1_byp_reg, s1_word;
      logic [BE_WIDTH-1:0]   s1_mask_reg;
      logic                  s1_valid_reg;

      for (gj = 0; gj < BE_WIDTH; gj++) begin : g_lane
        logic hit_a, hit_b;
        assign hit_a = wr_a && byte_en_a[gj] && (addr_a == addr_p[gi]);
        assign hit_b = wr_b && byte_en_b[gj] && (addr_b == addr_p[gi]);
        assign byp_mask[gj] = (RDW_MODE == 1) && (hit_a || hit_b);
        assign byp_data[8*gj +: 8] = hit_a ? write_data_a[8*gj +: 8] : write_data_b[8*gj +: 8];
        assign s1_word[8*gj +: 8]  = s1_mask_reg[gj] ? s1_byp_reg[8*gj +: 8] : s1_old_reg[8*gj +: 8];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_reg <= 1'b0;
          s1_old_reg   <= '0;
          s1_byp_reg   <= '0;
          s1_mask_reg  <= '0;
        end else begin
          s1_valid_reg <= rd_acc[gi];
          if (rd_acc[gi]) begin
            s1_old_reg  <= mem[addr_p[gi]];
            s1_byp_reg  <= byp_data;
            s1_mask_reg <= byp_mask;
          end
        end
      end

      if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_reg;
        logic                  s2_valid_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
          end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) s2_data_reg <= s1_word;
          end
        end
        assign read_data_p[gi]  = s2_data_reg;
        assign read_valid_p[gi] = s2_valid_reg;
      end else begin : g_lat1
        assign read_data_p[gi]  = s1_word;
        assign read_valid_p[gi] = s1_valid_reg;
      end
    end
  endgenerate

  assign read_data_a  = read_data_p[0];
  assign read_data_b  = read_data_p[1];
  assign read_valid_a = read_valid_p[0];
  assign read_valid_b = read_valid_p[1];

endmodule

// File: tb/tb_dpram_be_pipe.sv
// Bench for dpram_be_pipe. Two instances share one stimulus stream:
// u_dut0 uses defaults (1-cycle read, old data on read-during-write),
// u_dut1 uses a 2-cycle read with new data on read-during-write.
module tb_dpram_be_pipe;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int BW    = 2;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear_req;
  logic [DW-1:0] write_data_a, write_data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          write_en_a, write_en_b, read_en_a, read_en_b;
  logic [BW-1:0] byte_en_a, byte_en_b;

  logic          ready0, coll0, rv0a, rv0b;
  logic [DW-1:0] rd0a, rd0b;
  logic          ready1, coll1, rv1a, rv1b;
  logic [DW-1:0] rd1a, rd1b;

  dpram_be_pipe u_dut0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready0), .collision(coll0),
    .write_data_a(write_data_a), .addr_a(addr_a), .write_en_a(write_en_a),
    .byte_en_a(byte_en_a), .read_en_a(read_en_a), .read_data_a(rd0a), .read_valid_a(rv0a),
    .write_data_b(write_data_b), .addr_b(addr_b), .write_en_b(write_en_b),
    .byte_en_b(byte_en_b), .read_en_b(read_en_b), .read_data_b(rd0b), .read_valid_b(rv0b)
  );

  dpram_be_pipe #(.RD_LATENCY(2), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready1), .collision(coll1),
    .write_data_a(write_data_a), .addr_a(addr_a), .write_en_a(write_en_a),
    .byte_en_a(byte_en_a), .read_en_a(read_en_a), .read_data_a(rd1a), .read_valid_a(rv1a),
    .write_data_b(write_data_b), .addr_b(addr_b), .write_en_b(write_en_b),
    .byte_en_b(byte_en_b), .read_en_b(read_en_b), .read_data_b(rd1b), .read_valid_b(rv1b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t q0a[$], q0b[$], q1a[$], q1b[$];
  logic [DW-1:0] mmem [DEPTH];
  bit            m_ready;
  int            m_cnt;
  bit            exp_coll;
  logic [DW-1:0] last [4];
  string         pname [4] = '{"dut0.a", "dut0.b", "dut1.a", "dut1.b"};

  // Word at address a once this cycle's writes land (A wins shared lanes).
  function automatic logic [DW-1:0] after_write(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = mmem[a];
    for (int i = 0; i < BW; i++) begin
      if (write_en_a && addr_a == a && byte_en_a[i])      w[8*i +: 8] = write_data_a[8*i +: 8];
      else if (write_en_b && addr_b == a && byte_en_b[i]) w[8*i +: 8] = write_data_b[8*i +: 8];
    end
    return w;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
  endtask

  // Account for the clock edge that follows the inputs just driven.
  task automatic model_issue();
    logic [DW-1:0] na, nb;
    if (m_ready) begin
      exp_coll = (addr_a == addr_b) && (write_en_a || read_en_a) &&
                 (write_en_b || read_en_b) && (write_en_a || write_en_b);
      na = after_write(addr_a);
      nb = after_write(addr_b);
      if (read_en_a) begin
        q0a.push_back('{mmem[addr_a], cyc + 1});
        q1a.push_back('{na, cyc + 2});
      end
      if (read_en_b) begin
        q0b.push_back('{mmem[addr_b], cyc + 1});
        q1b.push_back('{nb, cyc + 2});
      end
      if (write_en_a) mmem[addr_a] = na;
      if (write_en_b) mmem[addr_b] = nb;
      if (clear_req) begin
        m_ready = 0;
        m_cnt   = 0;
        model_zero();
      end
    end else begin
      exp_coll = 0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1;
    end
  endtask

  // ---------------- comparisons ----------------
  task automatic cmp1(input string n, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  task automatic cmp16(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  task automatic check_ctrl();
    cmp1("ready0", ready0, m_ready);
    cmp1("ready1", ready1, m_ready);
    cmp1("collision0", coll0, exp_coll);
    cmp1("collision1", coll1, exp_coll);
  endtask

  // ---------------- monitor ----------------
  task automatic mon_port(input int p, input logic v, input logic [DW-1:0] d);
    exp_t e;
    bit   have;
    have = 0;
    case (p)
      0: if (q0a.size() > 0 && q0a[0].due == cyc) begin e = q0a.pop_front(); have = 1; end
      1: if (q0b.size() > 0 && q0b[0].due == cyc) begin e = q0b.pop_front(); have = 1; end
      2: if (q1a.size() > 0 && q1a[0].due == cyc) begin e = q1a.pop_front(); have = 1; end
      default: if (q1b.size() > 0 && q1b[0].due == cyc) begin e = q1b.pop_front(); have = 1; end
    endcase
    tests++;
    if (have || v === 1'b1) begin
      if (!have) begin
        fails++;
        $display("FAIL unexpected_valid %s: read_valid=1 data=%h, no read due (cycle %0d)", pname[p], d, cyc);
      end else if (v !== 1'b1) begin
        fails++;
        $display("FAIL missing_valid %s: read_valid=%b, expected 1 with data %h (cycle %0d)", pname[p], v, e.d, cyc);
      end else if (d !== e.d) begin
        fails++;
        $display("FAIL read_data %s: got %h expected %h (cycle %0d)", pname[p], d, e.d, cyc);
      end else begin
        $display("[TB] read %s data=%h ok (cycle %0d)", pname[p], d, cyc);
      end
    end else if (d !== last[p]) begin
      fails++;
      $display("FAIL hold %s: read_data moved to %h, expected to hold %h (cycle %0d)", pname[p], d, last[p], cyc);
    end
    if (v === 1'b1) last[p] = d;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon_port(0, rv0a, rd0a);
      mon_port(1, rv0b, rd0b);
      mon_port(2, rv1a, rd1a);
      mon_port(3, rv1b, rd1b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    clear_req = 0;
    write_en_a = 0; read_en_a = 0; addr_a = '0; write_data_a = '0; byte_en_a = '0;
    write_en_b = 0; read_en_b = 0; addr_b = '0; write_data_b = '0; byte_en_b = '0;
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    #1;
    check_ctrl();
    set_idle();
  endtask

  task automatic idle_cycle();
    cyc_begin();
    model_issue();
  endtask

  task automatic wa(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    write_en_a = 1; addr_a = a; write_data_a = d; byte_en_a = be;
  endtask
  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    write_en_b = 1; addr_b = a; write_data_b = d; byte_en_b = be;
  endtask
  task automatic ra(input logic [AW-1:0] a);
    read_en_a = 1; addr_a = a;
  endtask
  task automatic rb(input logic [AW-1:0] a);
    read_en_b = 1; addr_b = a;
  endtask

  task automatic rand_inputs(input int amax);
    write_en_a   = 1'($urandom_range(0, 1));
    read_en_a    = 1'($urandom_range(0, 1));
    addr_a       = AW'($urandom_range(0, amax));
    write_data_a = DW'($urandom);
    byte_en_a    = BW'($urandom);
    write_en_b   = 1'($urandom_range(0, 1));
    read_en_b    = 1'($urandom_range(0, 1));
    addr_b       = AW'($urandom_range(0, amax));
    write_data_b = DW'($urandom);
    byte_en_b    = BW'($urandom);
  endtask

  // Wait for ready, optionally throwing random requests that must be ignored.
  task automatic wait_ready(input bit junk);
    for (int i = 0; i < DEPTH + 8 && !m_ready; i++) begin
      cyc_begin();
      if (junk) rand_inputs(DEPTH - 1);
      model_issue();
    end
    cmp1("init_done", m_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    set_idle();
    rst = 1;
    #1;
    cmp1("rst_ready0", ready0, 1'b0);
    cmp1("rst_ready1", ready1, 1'b0);
    cmp1("rst_coll0", coll0, 1'b0);
    cmp1("rst_coll1", coll1, 1'b0);
    cmp1("rst_valid0a", rv0a, 1'b0);
    cmp1("rst_valid0b", rv0b, 1'b0);
    cmp1("rst_valid1a", rv1a, 1'b0);
    cmp1("rst_valid1b", rv1b, 1'b0);
    cmp16("rst_data0a", rd0a, '0);
    cmp16("rst_data0b", rd0b, '0);
    cmp16("rst_data1a", rd1a, '0);
    cmp16("rst_data1b", rd1b, '0);
    q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
    m_ready  = 0;
    m_cnt    = 0;
    exp_coll = 0;
    model_zero();
    for (int i = 0; i < 4; i++) last[i] = '0;
    mon_en = 1;
    @(negedge clk);
    #1;
    rst = 0;
    model_issue();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    set_idle();
    do_reset();
    wait_ready(1'b0);
    $display("[TB] init sweep complete at cycle %0d", cyc);

    // zero after init
    cyc_begin(); ra(8'd0); rb(8'd128); model_issue();
    cyc_begin(); ra(8'd255); model_issue();

    // byte lanes
    cyc_begin(); wa(8'd12, 16'h1234, 2'b11); model_issue();
    cyc_begin(); wa(8'd12, 16'hABCD, 2'b01); model_issue();
    cyc_begin(); wa(8'd12, 16'hFFFF, 2'b00); model_issue();
    cyc_begin(); ra(8'd12); model_issue();

    // back-to-back pipelined reads on B
    cyc_begin(); wb(8'd1, 16'h0011, 2'b11); model_issue();
    cyc_begin(); wb(8'd2, 16'h0022, 2'b11); model_issue();
    cyc_begin(); wb(8'd3, 16'h0033, 2'b11); model_issue();
    for (int i = 1; i <= 3; i++) begin
      cyc_begin(); rb(AW'(i)); model_issue();
    end

    // write-write collisions
    cyc_begin(); wa(8'd182, 16'hAAAA, 2'b11); wb(8'd182, 16'hBBBB, 2'b10); model_issue();
    cyc_begin(); ra(8'd182); model_issue();
    cyc_begin(); wa(8'd182, 16'hAAAA, 2'b01); wb(8'd182, 16'hBBBB, 2'b10); model_issue();
    cyc_begin(); ra(8'd182); model_issue();

    // read during write, cross-port and same-port
    cyc_begin(); wa(8'd5, 16'h0001, 2'b11); model_issue();
    cyc_begin(); wa(8'd5, 16'h0002, 2'b11); rb(8'd5); model_issue();
    cyc_begin(); wa(8'd7, 16'h5A5A, 2'b10); read_en_a = 1; model_issue();
    cyc_begin(); rb(8'd7); ra(8'd7); model_issue();
    idle_cycle();
    idle_cycle();

    // randomized traffic on a small address window to force conflicts
    for (int i = 0; i < 400; i++) begin
      cyc_begin();
      rand_inputs(7);
      model_issue();
    end
    idle_cycle();
    idle_cycle();

    // reset one cycle after reads are issued
    cyc_begin(); ra(8'd12); rb(8'd5); model_issue();
    do_reset();
    wait_ready(1'b1);

    // clear in RUN, then confirm memory re-zeroed
    cyc_begin(); wa(8'd12, 16'hBEEF, 2'b11); model_issue();
    cyc_begin(); clear_req = 1; model_issue();
    wait_ready(1'b1);
    cyc_begin(); ra(8'd12); rb(8'd182); model_issue();

    for (int i = 0; i < 4; i++) idle_cycle();

    cmp1("drain_q0a", q0a.size() == 0, 1'b1);
    cmp1("drain_q0b", q0b.size() == 0, 1'b1);
    cmp1("drain_q1a", q1a.size() == 0, 1'b1);
    cmp1("drain_q1b", q1b.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
